// File: rtl/ahb_pkg.sv
// Shared types and helpers for the AHB slave memory: FSM encoding, response
// and size codes, and the write byte-enable mask computation.
package ahb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_DATA = 3'd2,
      ST_ERR1 = 3'd3,
      ST_ERR2 = 3'd4
   } state_t;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   // Byte lanes of a 32-bit word touched by a transfer of the given size.
   function automatic logic [3:0] byte_mask(input logic [2:0] size,
                                            input logic [1:0] addr_lo);
      logic [3:0] mask;
      case (size)
         HSIZE_BYTE: mask = 4'b0001 << addr_lo;
         HSIZE_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
         default:    mask = 4'b1111;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/ahb_slave_mem_if.sv
// Master-to-slave AHB signal bundle for ahb_slave_mem.
interface ahb_slave_mem_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int SLAVES_NUM = 4
);
   localparam int HSEL_W = $clog2(SLAVES_NUM);

   logic [HSEL_W-1:0]     HSEL;
   logic [ADDR_WIDTH-1:0] HADDR;
   logic                  HWRITE;
   logic [2:0]            HSIZE;
   logic                  HREQ;
   logic                  HREADY;
   logic [DATA_WIDTH-1:0] HWDATA;
   logic [DATA_WIDTH-1:0] HRDATA;
   logic                  hreadyout;
   logic                  hresp;

   modport master (
      output HSEL, HADDR, HWRITE, HSIZE, HREQ, HREADY, HWDATA,
      input  HRDATA, hreadyout, hresp
   );

   modport slave (
      input  HSEL, HADDR, HWRITE, HSIZE, HREQ, HREADY, HWDATA,
      output HRDATA, hreadyout, hresp
   );

endinterface

// File: rtl/ahb_slave_regfile.sv
// Word-addressed register file: one byte-enabled write port, one registered
// read port, and same-edge forwarding of write data onto the read port.
module ahb_slave_regfile #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int IDX_W      = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [IDX_W-1:0]        wr_idx,
   input  logic [DATA_WIDTH/8-1:0] wr_be,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic                    rd_en,
   input  logic [IDX_W-1:0]        rd_idx,
   output logic [DATA_WIDTH-1:0]   rdata
);
   localparam int NB = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_word;

   // NOTE: the array has no reset so it maps onto plain storage; only rdata resets.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) mem[wr_idx][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   // NOTE: rd_word is assigned first on every path so no latch is inferred.
   always_comb begin
      rd_word = mem[rd_idx];
      if (wr_en && (wr_idx == rd_idx)) begin
         for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) rd_word[b*8 +: 8] = wdata[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)        rdata <= '0;
      else if (rd_en) rdata <= rd_word;
   end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB data-phase responder serving word reads/writes from a local register file.
// Optional byte/halfword writes are enabled by defining AHB_SLAVE_BYTE_LANE_EN.
module ahb_slave_mem
   import ahb_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    SLAVES_NUM  = 4,
   parameter int                    SLAVE_ID    = 0,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000,
   parameter int                    DEPTH       = 16,
   parameter int                    WAIT_STATES = 0
) (
   input logic             HCLK,
   input logic             HRESET,
   ahb_slave_mem_if.slave  bus
);
   localparam int                    NB        = DATA_WIDTH / 8;
   localparam int                    HSEL_W    = $clog2(SLAVES_NUM);
   localparam int                    IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(DEPTH * 4);
   localparam logic [3:0]            WS_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t                state, state_nxt;
   logic [3:0]            wait_cnt;
   logic [IDX_W-1:0]      idx_q;
   logic                  wr_q;
   logic [NB-1:0]         be_q;

   logic                  hreadyout_c, hresp_c;
   logic                  sel_valid, in_range, size_err, req_err;
   logic [ADDR_WIDTH-1:0] offset;
   logic [IDX_W-1:0]      idx_d, rd_idx;
   logic [NB-1:0]         be_d;
   logic                  enter_data, rd_en, wr_en;

   // Address-phase decode of the incoming request.
   assign sel_valid = bus.HREQ & bus.HREADY & (bus.HSEL == HSEL_W'(SLAVE_ID)) & hreadyout_c;
   assign offset    = bus.HADDR - BASE_ADDR;
   assign in_range  = (bus.HADDR >= BASE_ADDR) && (offset < WIN_BYTES);
   assign idx_d     = offset[IDX_W+1:2];
   assign req_err   = !in_range || size_err;

`ifdef AHB_SLAVE_BYTE_LANE_EN
   always_comb begin
      size_err = (bus.HSIZE > HSIZE_WORD) || ((bus.HSIZE == HSIZE_HALF) && bus.HADDR[0]);
      be_d     = NB'(byte_mask(bus.HSIZE, bus.HADDR[1:0]));
   end
`else
   logic unused_bits;
   assign size_err    = 1'b0;
   assign be_d        = '1;
   assign unused_bits = ^{bus.HSIZE, bus.HADDR[1:0]};
`endif

   always_ff @(posedge HCLK) begin
      if (HRESET) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE, ST_DATA, ST_ERR2: begin
            if (!sel_valid)         state_nxt = ST_IDLE;
            else if (req_err)       state_nxt = ST_ERR1;
            else if (WAIT_STATES > 0) state_nxt = ST_WAIT;
            else                    state_nxt = ST_DATA;
         end
         ST_WAIT: if (wait_cnt == 4'd0) state_nxt = ST_DATA;
         ST_ERR1: state_nxt = ST_ERR2;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      hreadyout_c = 1'b1;
      hresp_c     = HRESP_OKAY;
      case (state)
         ST_WAIT: hreadyout_c = 1'b0;
         ST_ERR1: begin
            hreadyout_c = 1'b0;
            hresp_c     = HRESP_ERROR;
         end
         ST_ERR2: hresp_c = HRESP_ERROR;
         default: ;
      endcase
   end

   // Captured address phase plus the wait-state countdown.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         wait_cnt <= 4'd0;
         idx_q    <= '0;
         wr_q     <= 1'b0;
         be_q     <= '0;
      end else begin
         if (sel_valid) begin
            idx_q    <= idx_d;
            wr_q     <= bus.HWRITE;
            be_q     <= be_d;
            wait_cnt <= WS_LOAD;
         end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
      end
   end

   // Reads are registered on the edge that enters DATA; a read accepted straight
   // out of IDLE/DATA/ERR2 uses the live address, one leaving WAIT the captured one.
   assign enter_data = (sel_valid && !req_err && (WAIT_STATES == 0)) ||
                       ((state == ST_WAIT) && (wait_cnt == 4'd0));
   assign rd_en      = enter_data && (sel_valid ? !bus.HWRITE : !wr_q);
   assign rd_idx     = sel_valid ? idx_d : idx_q;
   assign wr_en      = (state == ST_DATA) && wr_q && !HRESET;

   assign bus.hreadyout = hreadyout_c;
   assign bus.hresp     = hresp_c;

   ahb_slave_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .IDX_W      (IDX_W)
   ) u_regfile (
      .clk    (HCLK),
      .rst    (HRESET),
      .wr_en  (wr_en),
      .wr_idx (idx_q),
      .wr_be  (be_q),
      .wdata  (bus.HWDATA),
      .rd_en  (rd_en),
      .rd_idx (rd_idx),
      .rdata  (bus.HRDATA)
   );

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: a zero-wait and a three-wait instance,
// table-driven single transfers plus hand-written pipelining and reset sequences.
module tb_ahb_slave_mem;

   logic HCLK;
   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   logic [1:0]  hsel_d   [2];
   logic [31:0] haddr_d  [2];
   logic        hwrite_d [2];
   logic [2:0]  hsize_d  [2];
   logic        hreq_d   [2];
   logic        hready_d [2];
   logic [31:0] hwdata_d [2];
   logic        rst_d    [2];
   logic [31:0] rdata_o  [2];
   logic        rdy_o    [2];
   logic        resp_o   [2];

   ahb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SLAVES_NUM(4)) bus0 ();
   ahb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SLAVES_NUM(4)) bus3 ();

   assign bus0.HSEL = hsel_d[0];   assign bus3.HSEL = hsel_d[1];
   assign bus0.HADDR = haddr_d[0]; assign bus3.HADDR = haddr_d[1];
   assign bus0.HWRITE = hwrite_d[0]; assign bus3.HWRITE = hwrite_d[1];
   assign bus0.HSIZE = hsize_d[0]; assign bus3.HSIZE = hsize_d[1];
   assign bus0.HREQ = hreq_d[0];   assign bus3.HREQ = hreq_d[1];
   assign bus0.HREADY = hready_d[0]; assign bus3.HREADY = hready_d[1];
   assign bus0.HWDATA = hwdata_d[0]; assign bus3.HWDATA = hwdata_d[1];
   assign rdata_o[0] = bus0.HRDATA; assign rdata_o[1] = bus3.HRDATA;
   assign rdy_o[0] = bus0.hreadyout; assign rdy_o[1] = bus3.hreadyout;
   assign resp_o[0] = bus0.hresp;  assign resp_o[1] = bus3.hresp;

   ahb_slave_mem #(
      .SLAVE_ID(1), .BASE_ADDR(32'h100), .DEPTH(16), .WAIT_STATES(0)
   ) dut0 (.HCLK(HCLK), .HRESET(rst_d[0]), .bus(bus0));

   ahb_slave_mem #(
      .SLAVE_ID(1), .BASE_ADDR(32'h100), .DEPTH(16), .WAIT_STATES(3)
   ) dut3 (.HCLK(HCLK), .HRESET(rst_d[1]), .bus(bus3));

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One non-pipelined transfer, started just after a rising edge. Returns the
   // HRDATA/hresp seen in the completing cycle and the hreadyout-low cycle count.
   task automatic xfer(input int d, input logic req, input logic [1:0] sel,
                       input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output logic err, output int waits);
      bit done;
      hreq_d[d]   = req;
      hsel_d[d]   = sel;
      hwrite_d[d] = wr;
      haddr_d[d]  = addr;
      hsize_d[d]  = size;
      @(posedge HCLK); #1;
      hreq_d[d]   = 1'b0;
      hwdata_d[d] = wdata;
      waits = 0;
      done  = 0;
      rdata = '0;
      err   = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge HCLK);
         if (rdy_o[d]) begin
            done  = 1;
            rdata = rdata_o[d];
            err   = resp_o[d];
         end else begin
            waits++;
         end
         @(posedge HCLK); #1;
      end
      if (!done) waits = 99;
   endtask

   typedef struct {
      string       name;
      logic        req;
      logic [1:0]  sel;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_waits;
   } vec_t;

   vec_t vecs [14];

   initial begin
      logic [31:0] rd;
      logic        er;
      int          ws;

      vecs[0]  = '{"wr_104",      1'b1, 2'd1, 1'b1, 32'h104, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 0};
      vecs[1]  = '{"rd_104",      1'b1, 2'd1, 1'b0, 32'h104, 32'h0,         32'hDEAD_BEEF, 1'b0, 0};
      vecs[2]  = '{"wr_last",     1'b1, 2'd1, 1'b1, 32'h13C, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b0, 0};
      vecs[3]  = '{"rd_last",     1'b1, 2'd1, 1'b0, 32'h13C, 32'h0,         32'hCAFE_F00D, 1'b0, 0};
      vecs[4]  = '{"wr_first",    1'b1, 2'd1, 1'b1, 32'h100, 32'h0BAD_C0DE, 32'hCAFE_F00D, 1'b0, 0};
      vecs[5]  = '{"rd_first",    1'b1, 2'd1, 1'b0, 32'h100, 32'h0,         32'h0BAD_C0DE, 1'b0, 0};
      vecs[6]  = '{"rd_oor_200",  1'b1, 2'd1, 1'b0, 32'h200, 32'h0,         32'h0BAD_C0DE, 1'b1, 1};
      vecs[7]  = '{"wr_oor_140",  1'b1, 2'd1, 1'b1, 32'h140, 32'h5555_5555, 32'h0BAD_C0DE, 1'b1, 1};
      vecs[8]  = '{"rd_oor_0fc",  1'b1, 2'd1, 1'b0, 32'h0FC, 32'h0,         32'h0BAD_C0DE, 1'b1, 1};
      vecs[9]  = '{"wr_hsel2",    1'b1, 2'd2, 1'b1, 32'h104, 32'h1111_1111, 32'h0BAD_C0DE, 1'b0, 0};
      vecs[10] = '{"wr_noreq",    1'b0, 2'd1, 1'b1, 32'h100, 32'h2222_2222, 32'h0BAD_C0DE, 1'b0, 0};
      vecs[11] = '{"rd_104_keep", 1'b1, 2'd1, 1'b0, 32'h104, 32'h0,         32'hDEAD_BEEF, 1'b0, 0};
      vecs[12] = '{"rd_106_lo",   1'b1, 2'd1, 1'b0, 32'h106, 32'h0,         32'hDEAD_BEEF, 1'b0, 0};
      vecs[13] = '{"rd_100_keep", 1'b1, 2'd1, 1'b0, 32'h100, 32'h0,         32'h0BAD_C0DE, 1'b0, 0};

      for (int d = 0; d < 2; d++) begin
         hsel_d[d] = '0; haddr_d[d] = '0; hwrite_d[d] = 1'b0; hsize_d[d] = 3'd2;
         hreq_d[d] = 1'b0; hready_d[d] = 1'b1; hwdata_d[d] = '0; rst_d[d] = 1'b1;
      end
      repeat (2) @(posedge HCLK);
      #1;
      rst_d[0] = 1'b0;
      rst_d[1] = 1'b0;
      @(negedge HCLK);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("reset_hreadyout[%0d]", d), 32'(rdy_o[d]), 32'd1);
         check($sformatf("reset_hresp[%0d]", d), 32'(resp_o[d]), 32'd0);
         check($sformatf("reset_hrdata[%0d]", d), rdata_o[d], 32'h0);
      end
      @(posedge HCLK); #1;

      // Zero-wait instance: table of single transfers.
      for (int i = 0; i < 14; i++) begin
         xfer(0, vecs[i].req, vecs[i].sel, vecs[i].wr, vecs[i].addr, 3'd2, vecs[i].wdata, rd, er, ws);
         check({vecs[i].name, "_waits"}, 32'(ws), 32'(vecs[i].exp_waits));
         check({vecs[i].name, "_hresp"}, 32'(er), 32'(vecs[i].exp_err));
         check({vecs[i].name, "_hrdata"}, rd, vecs[i].exp_rdata);
      end

      // Pipelined write then read of the same word: read data is forwarded.
      hreq_d[0] = 1'b1; hsel_d[0] = 2'd1; hwrite_d[0] = 1'b1; haddr_d[0] = 32'h10C;
      @(posedge HCLK); #1;
      hwdata_d[0] = 32'h1234_5678;
      hwrite_d[0] = 1'b0;
      @(posedge HCLK); #1;
      hreq_d[0] = 1'b0;
      @(negedge HCLK);
      check("b2b_fwd_hrdata", rdata_o[0], 32'h1234_5678);
      check("b2b_fwd_hreadyout", 32'(rdy_o[0]), 32'd1);
      @(posedge HCLK); #1;
      xfer(0, 1'b1, 2'd1, 1'b0, 32'h10C, 3'd2, 32'h0, rd, er, ws);
      check("b2b_stored_hrdata", rd, 32'h1234_5678);

      // Reset landing on the closing edge of a write discards it.
      xfer(0, 1'b1, 2'd1, 1'b1, 32'h110, 3'd2, 32'h3333_3333, rd, er, ws);
      hreq_d[0] = 1'b1; hsel_d[0] = 2'd1; hwrite_d[0] = 1'b1; haddr_d[0] = 32'h110;
      @(posedge HCLK); #1;
      hreq_d[0] = 1'b0;
      hwdata_d[0] = 32'h7777_7777;
      rst_d[0] = 1'b1;
      @(posedge HCLK); #1;
      rst_d[0] = 1'b0;
      @(negedge HCLK);
      check("rst_data_hreadyout", 32'(rdy_o[0]), 32'd1);
      check("rst_data_hresp", 32'(resp_o[0]), 32'd0);
      check("rst_data_hrdata", rdata_o[0], 32'h0);
      @(posedge HCLK); #1;
      xfer(0, 1'b1, 2'd1, 1'b0, 32'h110, 3'd2, 32'h0, rd, er, ws);
      check("rst_data_mem_kept", rd, 32'h3333_3333);

      // Three-wait instance.
      xfer(1, 1'b1, 2'd1, 1'b1, 32'h108, 3'd2, 32'h5A5A_1234, rd, er, ws);
      check("ws3_wr_waits", 32'(ws), 32'd3);
      xfer(1, 1'b1, 2'd1, 1'b0, 32'h108, 3'd2, 32'h0, rd, er, ws);
      check("ws3_rd_waits", 32'(ws), 32'd3);
      check("ws3_rd_hrdata", rd, 32'h5A5A_1234);
      check("ws3_rd_hresp", 32'(er), 32'd0);
      xfer(1, 1'b1, 2'd1, 1'b0, 32'h200, 3'd2, 32'h0, rd, er, ws);
      check("ws3_oor_waits", 32'(ws), 32'd1);
      check("ws3_oor_hresp", 32'(er), 32'd1);
      check("ws3_oor_hrdata", rd, 32'h5A5A_1234);
      xfer(1, 1'b1, 2'd1, 1'b1, 32'h110, 3'd2, 32'h0F0F_0F0F, rd, er, ws);

      // Reset during the wait states of a write to 0x110.
      hreq_d[1] = 1'b1; hsel_d[1] = 2'd1; hwrite_d[1] = 1'b1; haddr_d[1] = 32'h110;
      @(posedge HCLK); #1;
      hreq_d[1] = 1'b0;
      hwdata_d[1] = 32'hFFFF_FFFF;
      @(negedge HCLK);
      check("rst_wait_in_wait", 32'(rdy_o[1]), 32'd0);
      @(posedge HCLK); #1;
      rst_d[1] = 1'b1;
      @(posedge HCLK); #1;
      rst_d[1] = 1'b0;
      @(negedge HCLK);
      check("rst_wait_hreadyout", 32'(rdy_o[1]), 32'd1);
      check("rst_wait_hresp", 32'(resp_o[1]), 32'd0);
      check("rst_wait_hrdata", rdata_o[1], 32'h0);
      @(posedge HCLK); #1;
      xfer(1, 1'b1, 2'd1, 1'b0, 32'h110, 3'd2, 32'h0, rd, er, ws);
      check("rst_wait_mem_kept", rd, 32'h0F0F_0F0F);
      check("rst_wait_rd_waits", 32'(ws), 32'd3);

`ifdef AHB_SLAVE_BYTE_LANE_EN
      xfer(1, 1'b1, 2'd1, 1'b1, 32'h111, 3'd0, 32'h0000_AA00, rd, er, ws);
      check("byte_wr_hresp", 32'(er), 32'd0);
      xfer(1, 1'b1, 2'd1, 1'b0, 32'h110, 3'd2, 32'h0, rd, er, ws);
      check("byte_wr_lane1", rd, 32'h0F0F_AA0F);
      xfer(1, 1'b1, 2'd1, 1'b1, 32'h111, 3'd1, 32'hBBBB_BBBB, rd, er, ws);
      check("half_misaligned_hresp", 32'(er), 32'd1);
      check("half_misaligned_waits", 32'(ws), 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
AHB data-phase responder sitting directly downstream of the AHB master. It decodes the master's encoded HSEL and HREQ/HREADY, then serves word reads and writes from a local register-file memory. It inserts programmable wait states and returns a two-cycle ERROR response for out-of-window addresses. It drives the master's hreadyout, hresp and HRDATA inputs.

Parameters:
ADDR_WIDTH, 32, address bus width
DATA_WIDTH, 32, data bus width (multiple of 8)
SLAVES_NUM, 4, number of slaves; sets HSEL width = $clog2(SLAVES_NUM)
SLAVE_ID, 0, HSEL code this instance responds to
BASE_ADDR, 32'h0000_0000, first byte address of the window
DEPTH, 16, number of DATA_WIDTH words; the window is DEPTH*4 bytes
WAIT_STATES, 0, hreadyout-low cycles per transfer (0..15)

Ports:
HCLK  in  1  clock; all logic on the rising edge
HRESET  in  1  synchronous, active-high reset
HSEL  in  $clog2(SLAVES_NUM)  encoded slave select from master
HADDR  in  ADDR_WIDTH  byte address (address phase)
HWRITE  in  1  1 = write, 0 = read (address phase)
HSIZE  in  3  transfer size; used only with the optional feature
HREQ  in  1  master transfer request
HREADY  in  1  master ready qualifier
HWDATA  in  DATA_WIDTH  write data (data phase, one cycle after address)
HRDATA  out  DATA_WIDTH  read data
hreadyout  out  1  1 = data phase completes this cycle
hresp  out  1  0 = OKAY, 1 = ERROR

Behaviour:
- Reset (HRESET=1 at an edge): state=IDLE, wait counter=0, HRDATA=0, hreadyout=1, hresp=0, pending write dropped. Memory contents are not reset.
- sel_valid = HREQ & HREADY & (HSEL==SLAVE_ID) & hreadyout. The address phase is sampled at the edge where sel_valid=1, capturing HADDR, HWRITE and HSIZE.
- in_range = (HADDR >= BASE_ADDR) & (HADDR < BASE_ADDR+DEPTH*4). The word index is (HADDR-BASE_ADDR)>>2. HADDR[1:0] is ignored unless the optional feature is enabled.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: on sel_valid & !in_range -> ERR1. On sel_valid & in_range -> WAIT if WAIT_STATES>0, else DATA. Otherwise stay in IDLE.
  - WAIT: hreadyout=0, hresp=0. The counter loads WAIT_STATES-1 and decrements; at 0 -> DATA.
  - DATA: hreadyout=1, hresp=0; the transfer completes at the closing edge.
    - Write: mem[idx] <= HWDATA at that edge.
    - Read: HRDATA is valid throughout DATA. It is registered from mem[idx] at the edge entering DATA.
    - A new sel_valid in DATA is accepted in the same cycle (pipelined back-to-back) and follows the IDLE rules; with no new request -> IDLE.
  - ERR1: hreadyout=0, hresp=1 -> ERR2.
  - ERR2: hreadyout=1, hresp=1 -> IDLE. No memory update; HRDATA holds its value. New requests are ignored in ERR1; in ERR2 they are accepted as in DATA.
- Latency with WAIT_STATES=0: read data is available 1 cycle after the address edge. Otherwise 1+WAIT_STATES cycles.
- Read-after-write hazard: when a read is accepted in the same cycle a write to the same index completes, HRDATA takes the forwarded HWDATA.
- HSEL mismatch or HREQ=0 leaves the block in IDLE with hreadyout=1 and hresp=0.
- HRESET asserted during WAIT, DATA or ERR*: reset values apply at that edge and any in-flight write is discarded.

Optional Feature:
AHB_SLAVE_BYTE_LANE_EN.
- Defined: HSIZE 0/1/2 selects byte/halfword/word writes; lanes are chosen by HADDR[1:0]. A misaligned halfword (HADDR[0]=1) or HSIZE>2 gives the ERROR response. Reads always return the full word.
- Undefined: HSIZE and HADDR[1:0] are ignored and every write is full-word.

Decomposition:
- Package ahb_pkg holds:
  - FSM state encoding
  - HRESP_OKAY/HRESP_ERROR
  - HSIZE_BYTE/HALF/WORD
  - the function computing the byte-enable mask from HSIZE and addr[1:0]
- Sub-module ahb_slave_regfile: DEPTH x DATA_WIDTH array with one write port (byte enables), one synchronous read port and same-cycle write-to-read forwarding.

Test Plan:
1. SLAVE_ID=1, BASE=0x100, WAIT_STATES=0. Write 0xDEAD_BEEF to 0x104, then read 0x104 -> hreadyout stays 1, HRDATA=0xDEAD_BEEF one cycle after the read address, hresp=0.
2. WAIT_STATES=3. Read 0x108 -> hreadyout low for exactly 3 cycles, then high for 1 cycle with the stored data.
3. Access 0x200 (out of range) -> hresp=1 for 2 cycles, hreadyout 0 then 1; a follow-up read of the old data at 0x104 is unchanged.
4. HSEL=2 with HREQ=1 -> no state change, no memory write, hreadyout=1.
5. Back-to-back write 0x1234_5678 to 0x10C followed immediately by a read of 0x10C -> HRDATA=0x1234_5678 via forwarding.
6. HRESET pulsed in the WAIT of a write to 0x110 -> outputs return to reset values and a later read of 0x110 returns the prior contents.
   - With AHB_SLAVE_BYTE_LANE_EN: an HSIZE=0 write of 0xAA to 0x111 changes only byte 1.
